// File: rtl/gram_sparse_mv.sv
// Streaming Gram-matrix builder (G = X^T X, upper triangle) with optional per-row
// mean sparsification, followed by a matrix-vector product y = G' * w.
module gram_sparse_mv #(
  parameter int unsigned D  = 8,
  parameter int unsigned L  = 16,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          thr_en,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          o_last
);

  localparam int unsigned CW = $clog2(D);
  localparam int unsigned KW = $clog2(L * D);
  localparam int unsigned NT = D * (D + 1) / 2;
  localparam int unsigned GW = 2 * DW + $clog2(L) + 1;
  localparam int unsigned SW = GW + CW;
  localparam int unsigned AW = GW + DW + CW;

  typedef enum logic [1:0] {S_IN, S_MEAN, S_W, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   w_cnt_q, w_cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            thr_q, thr_d;
  logic [GW-1:0]   g_q [NT];
  logic [GW-1:0]   g_d [NT];
  logic [DW-1:0]   rowbuf_q [D];
  logic [DW-1:0]   rowbuf_d [D];
  logic [AW-1:0]   acc_q [D];
  logic [AW-1:0]   acc_d [D];
  logic [D-1:0]    mask_q [D];
  logic [D-1:0]    mask_d [D];
  logic [GW-1:0]   gfull [D][D];
  logic [CW-1:0]   col;

  // Packed upper-triangle index for a <= b
  function automatic int unsigned tri_idx(int unsigned a, int unsigned b);
    return a * D - (a * (a - 1)) / 2 + b - a;
  endfunction

  assign col = in_cnt_q[CW-1:0];

  always_comb begin
    for (int unsigned a = 0; a < D; a++) begin
      for (int unsigned b = 0; b < D; b++) begin
        gfull[a][b] = (a <= b) ? g_q[tri_idx(a, b)] : g_q[tri_idx(b, a)];
      end
    end
  end

  always_comb begin : next_state
    logic [DW-1:0] op;
    logic [SW-1:0] sum;
    logic [GW-1:0] mean;
    op       = '0;
    sum      = '0;
    mean     = '0;
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    w_cnt_d  = w_cnt_q;
    idx_d    = idx_q;
    thr_d    = thr_q;
    g_d      = g_q;
    rowbuf_d = rowbuf_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    case (state_q)
      S_IN: begin
        if (i_valid) begin
          for (int unsigned a = 0; a < D; a++) begin
            for (int unsigned b = a; b < D; b++) begin
              if (CW'(b) == col) begin
                op = (a == b) ? i_data : rowbuf_q[a];
                g_d[tri_idx(a, b)] = g_q[tri_idx(a, b)] + GW'(op) * GW'(i_data);
              end
            end
          end
          rowbuf_d[col] = i_data;
          if (in_cnt_q == '0) thr_d = thr_en;
          if (in_cnt_q == KW'(L * D - 1)) begin
            in_cnt_d = '0;
            state_d  = S_MEAN;
          end else begin
            in_cnt_d = in_cnt_q + KW'(1);
          end
        end
      end
      S_MEAN: begin
        // Row mean uses the full symmetric row; the resulting mask is per-row
        for (int unsigned a = 0; a < D; a++) begin
          sum = '0;
          for (int unsigned b = 0; b < D; b++) sum = sum + SW'(gfull[a][b]);
          mean = GW'(sum >> CW);
          for (int unsigned b = 0; b < D; b++) mask_d[a][b] = thr_q && (gfull[a][b] < mean);
        end
        state_d = S_W;
      end
      S_W: begin
        if (w_valid) begin
          for (int unsigned a = 0; a < D; a++) begin
            for (int unsigned b = 0; b < D; b++) begin
              if (CW'(b) == w_cnt_q && !mask_q[a][b]) begin
                acc_d[a] = acc_d[a] + AW'(gfull[a][b]) * AW'(w_data);
              end
            end
          end
          w_cnt_d = w_cnt_q + CW'(1);
          if (w_cnt_q == CW'(D - 1)) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (o_ready) begin
          if (idx_q == CW'(D - 1)) begin
            idx_d    = '0;
            thr_d    = 1'b0;
            g_d      = '{default: '0};
            rowbuf_d = '{default: '0};
            acc_d    = '{default: '0};
            mask_d   = '{default: '0};
            state_d  = S_IN;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IN;
      in_cnt_q <= '0;
      w_cnt_q  <= '0;
      idx_q    <= '0;
      thr_q    <= 1'b0;
      g_q      <= '{default: '0};
      rowbuf_q <= '{default: '0};
      acc_q    <= '{default: '0};
      mask_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      w_cnt_q  <= w_cnt_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      g_q      <= g_d;
      rowbuf_q <= rowbuf_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
    end
  end

  logic [OW-1:0] sel;
  generate
    if (AW >= OW) begin : g_trunc
      assign sel = acc_q[idx_q][OW-1:0];
    end else begin : g_ext
      assign sel = {{(OW - AW){1'b0}}, acc_q[idx_q]};
    end
  endgenerate

  assign i_ready = (state_q == S_IN);
  assign w_ready = (state_q == S_W);
  assign o_valid = (state_q == S_OUT);
  assign o_last  = (state_q == S_OUT) && (idx_q == CW'(D - 1));
  assign o_data  = (state_q == S_OUT) ? sel : '0;

endmodule

// File: tb/tb_gram_sparse_mv.sv
// Directed bench for gram_sparse_mv at D=8, L=16, DW=8, OW=32.
module tb_gram_sparse_mv;
  localparam int D = 8;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_ready;
  logic        thr_en = 1'b0;
  logic        w_valid = 1'b0;
  logic [7:0]  w_data = '0;
  logic        w_ready;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_last;

  int checks = 0;
  int failures = 0;

  gram_sparse_mv #(.D(D), .L(L), .DW(8), .OW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready), .thr_en(thr_en),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       xp;
    logic [1:0]       wp;
    logic             thr;
    logic [7:0][31:0] y;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] x_val(input int xp, input int k);
    int r, c;
    r = k / D;
    c = k % D;
    case (xp)
      0: return 8'd1;
      1: return (c == r % D) ? 8'd2 : 8'd0;
      2: return (c == 0) ? 8'd2 : 8'd1;
      default: return 8'd255;
    endcase
  endfunction

  function automatic logic [7:0] w_val(input int wp, input int b);
    case (wp)
      0: return 8'd1;
      1: return 8'(b + 1);
      default: return 8'd255;
    endcase
  endfunction

  task automatic send_x(input logic [7:0] v);
    int cyc;
    i_valid = 1'b1;
    i_data  = v;
    cyc = 0;
    while (!i_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!i_ready) chk("x_accept_timeout", 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] v);
    int cyc;
    w_valid = 1'b1;
    w_data  = v;
    cyc = 0;
    while (!w_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!w_ready) chk("w_accept_timeout", 32'(w_ready), 32'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  // thr_en flips after the first element; only the first sample may count
  task automatic send_frame(input int xp, input logic thr, input logic bogus_w);
    for (int k = 0; k < L * D; k++) begin
      thr_en = (k == 0) ? thr : ~thr;
      if (bogus_w && k < L * D - 8) begin
        w_valid = 1'b1;
        w_data  = 8'd99;
      end else begin
        w_valid = 1'b0;
      end
      if (k == 5) chk("w_ready_in_S_IN", 32'(w_ready), 32'd0);
      send_x(x_val(xp, k));
    end
    w_valid = 1'b0;
  endtask

  task automatic send_weights(input int wp, input int n, input logic bogus_i);
    if (bogus_i) begin
      i_valid = 1'b1;
      i_data  = 8'd77;
    end
    for (int b = 0; b < n; b++) begin
      send_w(w_val(wp, b));
      if (b == 1) chk("i_ready_in_S_W", 32'(i_ready), 32'd0);
    end
    i_valid = 1'b0;
  endtask

  task automatic recv(input logic [7:0][31:0] y, input int hold_idx);
    int cyc;
    for (int i = 0; i < D; i++) begin
      cyc = 0;
      while (!o_valid && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("o_valid[%0d]", i), 32'(o_valid), 32'd1);
      chk($sformatf("o_data[%0d]", i), o_data, y[i]);
      chk($sformatf("o_last[%0d]", i), 32'(o_last), (i == D - 1) ? 32'd1 : 32'd0);
      if (i == hold_idx) begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", o_data, y[i]);
        end
      end
      o_ready = 1'b1;
      @(posedge clk); #1;
      o_ready = 1'b0;
    end
    chk("no_extra_word", 32'(o_valid), 32'd0);
    chk("i_ready_after_frame", 32'(i_ready), 32'd1);
  endtask

  function automatic logic [7:0][31:0] fill(input logic [31:0] v);
    logic [7:0][31:0] r;
    for (int i = 0; i < D; i++) r[i] = v;
    return r;
  endfunction

  initial begin
    logic [7:0][31:0] y;
    vecs[0] = '{xp: 2'd0, wp: 2'd0, thr: 1'b1, y: fill(32'd128)};
    for (int a = 0; a < D; a++) y[a] = 32'(8 * (a + 1));
    vecs[1] = '{xp: 2'd1, wp: 2'd1, thr: 1'b1, y: y};
    y = fill(32'd32);
    y[0] = 32'd64;
    vecs[2] = '{xp: 2'd2, wp: 2'd0, thr: 1'b1, y: y};
    y = fill(32'd144);
    y[0] = 32'd288;
    vecs[3] = '{xp: 2'd2, wp: 2'd0, thr: 1'b0, y: y};
    vecs[4] = '{xp: 2'd3, wp: 2'd2, thr: 1'b0, y: fill(32'd2122416000)};
    // all G equal to its row mean: equality keeps every element
    vecs[5] = '{xp: 2'd3, wp: 2'd2, thr: 1'b1, y: fill(32'd2122416000)};

    #12;
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_i_ready", 32'(i_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      send_frame(int'(vecs[v].xp), vecs[v].thr, 1'b0);
      send_weights(int'(vecs[v].wp), D, 1'b0);
      recv(vecs[v].y, -1);
    end

    // Backpressure at word 2
    send_frame(0, 1'b1, 1'b0);
    send_weights(0, D, 1'b0);
    recv(fill(32'd128), 2);

    // Reset mid-weights, then a clean frame with stray valids on the idle side
    send_frame(2, 1'b0, 1'b0);
    send_weights(1, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_w_ready", 32'(w_ready), 32'd0);
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_i_ready", 32'(i_ready), 32'd1);
    send_frame(0, 1'b1, 1'b1);
    send_weights(0, D, 1'b1);
    recv(fill(32'd128), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gram_sparse_mv.md
GRAM_SPARSE_MV -- requirements
Module: gram_sparse_mv

Interface
REQ-001 Parameter D, default 8: feature count (columns of X, length of w, output words); power of two, 2..16.
REQ-002 Parameter L, default 16: rows of X per frame, 1..256.
REQ-003 Parameter DW, default 8: unsigned width of X and w elements.
REQ-004 Parameter OW, default 32: output word width.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_valid  in  1  X element offered.
REQ-008 i_data  in  DW  X element, row-major order.
REQ-009 i_ready  out  1  block accepts X elements.
REQ-010 thr_en  in  1  sparsify mode; sampled with the first X element of a frame.
REQ-011 w_valid  in  1  weight offered.
REQ-012 w_data  in  DW  weight w[b], b ascending.
REQ-013 w_ready  out  1  block accepts weights.
REQ-014 o_valid  out  1  o_data valid.
REQ-015 o_ready  in  1  consumer accepts o_data.
REQ-016 o_data  out  OW  result y[a], a ascending.
REQ-017 o_last  out  1  high with y[D-1].

Function
REQ-018 States: S_IN, S_MEAN, S_W, S_OUT; transfers occur only when valid and ready are both high; valid without ready is ignored.
REQ-019 S_IN: i_ready=1; element k maps to row k/D, column c=k%D; on accept, G[a][c] += rowbuf[a]*x for a<c, G[c][c] += x*x, rowbuf[c] <= x.
REQ-020 G is symmetric, upper triangle stored; element width GW = 2*DW + clog2(L)+1, unsigned, no overflow.
REQ-021 After element L*D-1 accepted -> S_MEAN for exactly 1 cycle; i_ready=0 from the next cycle.
REQ-022 S_MEAN: m[a] = floor((sum over b of G[a][b]) / D) using the full symmetric row; if latched thr_en=1, G'[a][b]=0 when G[a][b] < m[a], otherwise G'=G; equality keeps the element; thr_en=0 means G'=G.
REQ-023 Mask is per row and therefore asymmetric; G' is held as a full DxD mask over stored G.
REQ-024 S_W: w_ready=1; on each accept of w[b], acc[a] += G'[a][b]*w[b] for all a in parallel; after D weights -> S_OUT on the next cycle.
REQ-025 S_OUT: o_valid=1, o_data=acc[idx] mod 2^OW, o_last=(idx==D-1); idx advances only on o_ready; o_data is held stable while o_ready=0.
REQ-026 Accept of idx D-1 -> clear G, rowbuf, acc, mask, idx; -> S_IN; i_ready=1 on the next cycle.
REQ-027 i_valid outside S_IN, w_valid outside S_W, and o_ready outside S_OUT have no effect.
REQ-028 Latency: first o_valid no earlier than 1 cycle after the D-th weight accept.
REQ-029 thr_en changes mid-frame have no effect on the current frame.

Reset
REQ-030 rst_n low, at any time or in any state: state=S_IN, i_ready=1 after release, w_ready=0, o_valid=0, o_last=0, o_data=0, and G, acc, rowbuf, mask, counters cleared.
REQ-031 After a reset mid-frame, the next frame computes with no residue from the aborted frame.

Verification (D=8, L=16, DW=8, OW=32)
REQ-032 All X=1, all w=1, thr_en=1 -> G all 16, nothing masked, outputs 128 x8, o_last on the 8th word only.
REQ-033 X[r][r%8]=2 and all other elements 0; w[b]=b+1; thr_en=1 -> y[a]=8*(a+1).
REQ-034 X[r][0]=2 and other columns 1; w all 1; thr_en=1 -> y=64,32,32,32,32,32,32,32; the same frame with thr_en=0 -> 288,144 x7.
REQ-035 All X=255, all w=255, thr_en=0 -> each y = 2,122,416,000 (no truncation).
REQ-036 Scenario REQ-032 with o_ready low for 3 cycles at idx 2 -> word 2 held stable, exactly 8 words delivered, no duplicate or skipped word.
REQ-037 Reset asserted after 3 weights, then scenario REQ-032 -> outputs exactly 128 x8; i_valid during S_W and w_valid during S_IN are ignored.
